// File: rtl/regfile_stack_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// Shared types for the stacked register file and its push/pop sequencer.
//   Command   : command word driven into the stacked register file
//   CtrlState : sequencer states (run, drain-then-push, drain-then-pop)
//   PrioWidthDefault : default interrupt priority width
// ----------------------------------------------------------------------------
package veryl_stacked_regfile_RegFilePkg;

    localparam int PrioWidthDefault = 3;

    typedef enum logic [1:0] {
        Command_none = 2'd0,
        Command_push = 2'd1,
        Command_pop  = 2'd2
    } Command;

    typedef enum logic [2:0] {
        CtrlState_RUN         = 3'd0,
        CtrlState_ENTER_DRAIN = 3'd1,
        CtrlState_ENTER_PUSH  = 3'd2,
        CtrlState_EXIT_DRAIN  = 3'd3,
        CtrlState_EXIT_POP    = 3'd4
    } CtrlState;

endpackage

// File: rtl/regfile_stack_ctrl_prio_lifo.sv
// ----------------------------------------------------------------------------
// prio_lifo: LIFO of the priority levels of the active (nested) interrupts.
// Holds Depth-1 entries; o_top is the priority of the running context
// (0 = thread level when the LIFO is empty).
//   i_clk    : clock
//   i_reset  : asynchronous active-low reset, clears the LIFO
//   i_push   : push i_data (ignored when full)
//   i_pop    : pop top entry (ignored when empty)
//   i_data   : priority to push
//   o_top    : current top entry, 0 when empty
//   o_level  : number of valid entries
// ----------------------------------------------------------------------------
module prio_lifo
    import veryl_stacked_regfile_RegFilePkg::*;
#(
    parameter int Depth     = 4,
    parameter int PrioWidth = PrioWidthDefault
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [PrioWidth-1:0]     i_data,
    output logic [PrioWidth-1:0]     o_top,
    output logic [$clog2(Depth)-1:0] o_level
);

    localparam int MaxNest = Depth - 1;
    localparam int LvlW    = $clog2(Depth);

    logic [PrioWidth-1:0] r_mem [MaxNest];
    logic [LvlW-1:0]      r_level;
    logic [LvlW-1:0]      w_top_idx;

    assign w_top_idx = r_level - LvlW'(1);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_level <= '0;
            for (int i = 0; i < MaxNest; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_push && !i_pop && (r_level < LvlW'(MaxNest))) begin
            r_mem[r_level] <= i_data;
            r_level        <= r_level + LvlW'(1);
        end else if (i_pop && !i_push && (r_level != '0)) begin
            r_level <= r_level - LvlW'(1);
        end
    end

    // Empty LIFO means the core runs at thread level (priority 0).
    assign o_top   = (r_level == '0) ? '0 : r_mem[w_top_idx];
    assign o_level = r_level;

endmodule

// File: rtl/regfile_stack_ctrl.sv
// ----------------------------------------------------------------------------
// regfile_stack_ctrl: sequencer in front of the stacked register file.
// Accepts interrupt entry / return requests, drains the pipeline, then issues
// exactly one push (entry) or pop (return) command. Tracks nesting depth and
// the priority of each active level so only strictly higher priorities preempt.
//   i_clk, i_reset    : clock, asynchronous active-low reset
//   i_irq_valid/prio  : entry request (held until o_irq_ready)
//   o_irq_ready       : accept pulse, coincident with the push command
//   i_ret_valid       : return request (held until o_ret_ready)
//   o_ret_ready       : accept pulse, coincident with pop (or underflow)
//   i_pipe_idle       : no in-flight register writes
//   o_command         : none/push/pop to the stacked register file
//   o_stall           : front-end hold during drain and command cycles
//   o_level           : current nesting level
//   o_cur_prio        : priority of the running context
//   o_overflow        : sticky, preempting request refused at max nesting
//   o_underflow       : sticky, return received at level 0
// ----------------------------------------------------------------------------
module regfile_stack_ctrl
    import veryl_stacked_regfile_RegFilePkg::*;
#(
    parameter int Depth     = 4,
    parameter int PrioWidth = PrioWidthDefault
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_irq_valid,
    input  logic [PrioWidth-1:0]     i_irq_prio,
    output logic                     o_irq_ready,
    input  logic                     i_ret_valid,
    output logic                     o_ret_ready,
    input  logic                     i_pipe_idle,
    output Command                   o_command,
    output logic                     o_stall,
    output logic [$clog2(Depth)-1:0] o_level,
    output logic [PrioWidth-1:0]     o_cur_prio,
    output logic                     o_overflow,
    output logic                     o_underflow
);

    localparam int MaxNest = Depth - 1;
    localparam int LvlW    = $clog2(Depth);

    CtrlState             r_state;
    CtrlState             w_state_nxt;
    logic [PrioWidth-1:0] r_prio_lat;
    logic                 r_overflow;
    logic                 r_underflow;

    Command               w_command;
    logic                 w_irq_ready;
    logic                 w_ret_ready;
    logic                 w_stall;
    logic                 w_set_ovf;
    logic                 w_set_unf;
    logic                 w_latch;
    logic [PrioWidth-1:0] w_top;
    logic [LvlW-1:0]      w_level;

    prio_lifo #(
        .Depth     (Depth),
        .PrioWidth (PrioWidth)
    ) u_prio_lifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (r_state == CtrlState_ENTER_PUSH),
        .i_pop   (r_state == CtrlState_EXIT_POP),
        .i_data  (r_prio_lat),
        .o_top   (w_top),
        .o_level (w_level)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= CtrlState_RUN;
            r_prio_lat  <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch) begin
                r_prio_lat <= i_irq_prio;
            end
            if (w_set_ovf) begin
                r_overflow <= 1'b1;
            end
            if (w_set_unf) begin
                r_underflow <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_command   = Command_none;
        w_irq_ready = 1'b0;
        w_ret_ready = 1'b0;
        w_stall     = 1'b0;
        w_set_ovf   = 1'b0;
        w_set_unf   = 1'b0;
        w_latch     = 1'b0;
        case (r_state)
            CtrlState_RUN: begin
                // A return takes precedence; a concurrent interrupt simply
                // stays pending because it is not acknowledged.
                if (i_ret_valid) begin
                    if (w_level != '0) begin
                        w_state_nxt = CtrlState_EXIT_DRAIN;
                    end else begin
                        w_ret_ready = 1'b1;
                        w_set_unf   = 1'b1;
                    end
                end else if (i_irq_valid && (i_irq_prio > w_top)) begin
                    if (w_level < LvlW'(MaxNest)) begin
                        w_latch     = 1'b1;
                        w_state_nxt = CtrlState_ENTER_DRAIN;
                    end else begin
                        w_set_ovf = 1'b1;
                    end
                end
            end
            CtrlState_ENTER_DRAIN: begin
                w_stall = 1'b1;
                if (i_pipe_idle) begin
                    w_state_nxt = CtrlState_ENTER_PUSH;
                end
            end
            CtrlState_ENTER_PUSH: begin
                w_command   = Command_push;
                w_irq_ready = 1'b1;
                w_stall     = 1'b1;
                w_state_nxt = CtrlState_RUN;
            end
            CtrlState_EXIT_DRAIN: begin
                w_stall = 1'b1;
                if (i_pipe_idle) begin
                    w_state_nxt = CtrlState_EXIT_POP;
                end
            end
            CtrlState_EXIT_POP: begin
                w_command   = Command_pop;
                w_ret_ready = 1'b1;
                w_stall     = 1'b1;
                w_state_nxt = CtrlState_RUN;
            end
            default: begin
                w_state_nxt = CtrlState_RUN;
            end
        endcase
    end

    assign o_command   = w_command;
    assign o_irq_ready = w_irq_ready;
    // The underflow accept is combinational in RUN; masking with reset keeps
    // the pulse low while reset is held even if a return request is present.
    assign o_ret_ready = w_ret_ready & i_reset;
    assign o_stall     = w_stall;
    assign o_level     = w_level;
    assign o_cur_prio  = w_top;
    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;

endmodule

// File: tb/tb_regfile_stack_ctrl.sv
module tb_regfile_stack_ctrl;
    import veryl_stacked_regfile_RegFilePkg::*;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b0;
    logic       i_irq_valid = 1'b0;
    logic [2:0] i_irq_prio = '0;
    logic       o_irq_ready;
    logic       i_ret_valid = 1'b0;
    logic       o_ret_ready;
    logic       i_pipe_idle = 1'b1;
    Command     o_command;
    logic       o_stall;
    logic [1:0] o_level;
    logic [2:0] o_cur_prio;
    logic       o_overflow;
    logic       o_underflow;

    regfile_stack_ctrl #(.Depth(4), .PrioWidth(3)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_irq_valid (i_irq_valid),
        .i_irq_prio  (i_irq_prio),
        .o_irq_ready (o_irq_ready),
        .i_ret_valid (i_ret_valid),
        .o_ret_ready (o_ret_ready),
        .i_pipe_idle (i_pipe_idle),
        .o_command   (o_command),
        .o_stall     (o_stall),
        .o_level     (o_level),
        .o_cur_prio  (o_cur_prio),
        .o_overflow  (o_overflow),
        .o_underflow (o_underflow)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [1:0] cmd;
        logic       irq_rdy;
        logic       ret_rdy;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every command / accept pulse must match the next expectation.
    always @(negedge i_clk) begin
        if (o_command != Command_none || o_irq_ready || o_ret_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_event: got cmd=%0d irq_rdy=%0b ret_rdy=%0b at cycle %0d, expected none",
                         o_command, o_irq_ready, o_ret_ready, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("event_cmd",     32'(o_command),   32'(e.cmd));
                check("event_irq_rdy", 32'(o_irq_ready), 32'(e.irq_rdy));
                check("event_ret_rdy", 32'(o_ret_ready), 32'(e.ret_rdy));
                check("event_cycle",   32'(cyc),         32'(e.cyc));
            end
        end
    end

    task automatic sync();
        @(negedge i_clk);
        #1;
    endtask

    task automatic wait_irq_ready();
        bit done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge i_clk);
            if (o_irq_ready) done = 1;
        end
        if (!done) check("irq_ready_timeout", 32'd0, 32'd1);
        #1;
        i_irq_valid = 1'b0;
    endtask

    task automatic wait_ret_ready();
        bit done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge i_clk);
            if (o_ret_ready) done = 1;
        end
        if (!done) check("ret_ready_timeout", 32'd0, 32'd1);
        #1;
        i_ret_valid = 1'b0;
    endtask

    // Entry with idle pipe: push two cycles after the request is driven.
    task automatic do_irq(input logic [2:0] p);
        sync();
        exp_q.push_back('{Command_push, 1'b1, 1'b0, cyc + 2});
        i_irq_prio  = p;
        i_irq_valid = 1'b1;
        wait_irq_ready();
    endtask

    task automatic do_reset();
        sync();
        i_reset = 1'b0;
        @(negedge i_clk);
        check("rst_level", 32'(o_level), 32'd0);
        #1;
        i_reset = 1'b1;
    endtask

    initial begin
        // Reset held with a pending prio-3 interrupt
        i_irq_prio  = 3'd3;
        i_irq_valid = 1'b1;
        repeat (3) @(negedge i_clk);
        check("rst_command",   32'(o_command),   32'(Command_none));
        check("rst_irq_ready", 32'(o_irq_ready), 32'd0);
        check("rst_ret_ready", 32'(o_ret_ready), 32'd0);
        check("rst_stall",     32'(o_stall),     32'd0);
        check("rst_level0",    32'(o_level),     32'd0);
        check("rst_cur_prio",  32'(o_cur_prio),  32'd0);
        check("rst_overflow",  32'(o_overflow),  32'd0);
        check("rst_underflow", 32'(o_underflow), 32'd0);
        #1;
        exp_q.push_back('{Command_push, 1'b1, 1'b0, cyc + 2});
        i_reset = 1'b1;
        wait_irq_ready();
        @(negedge i_clk);
        check("rst_push_level", 32'(o_level),    32'd1);
        check("rst_push_prio",  32'(o_cur_prio), 32'd3);

        // Nesting: 2, 5 accepted; 4 held off until a return drops to prio 2
        do_reset();
        do_irq(3'd2);
        do_irq(3'd5);
        sync();
        i_irq_prio  = 3'd4;
        i_irq_valid = 1'b1;
        repeat (5) @(negedge i_clk);
        check("nest_level", 32'(o_level),    32'd2);
        check("nest_prio",  32'(o_cur_prio), 32'd5);
        #1;
        exp_q.push_back('{Command_pop,  1'b0, 1'b1, cyc + 2});
        exp_q.push_back('{Command_push, 1'b1, 1'b0, cyc + 5});
        i_ret_valid = 1'b1;
        wait_ret_ready();
        @(negedge i_clk);
        check("nest_pop_level", 32'(o_level),    32'd1);
        check("nest_pop_prio",  32'(o_cur_prio), 32'd2);
        wait_irq_ready();
        @(negedge i_clk);
        check("nest_p4_level", 32'(o_level),    32'd2);
        check("nest_p4_prio",  32'(o_cur_prio), 32'd4);

        // Pipe busy for six cycles
        do_reset();
        sync();
        i_pipe_idle = 1'b0;
        exp_q.push_back('{Command_push, 1'b1, 1'b0, cyc + 7});
        i_irq_prio  = 3'd1;
        i_irq_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge i_clk);
            check("busy_stall", 32'(o_stall),   32'd1);
            check("busy_cmd",   32'(o_command), 32'(Command_none));
        end
        #1;
        i_pipe_idle = 1'b1;
        wait_irq_ready();
        @(negedge i_clk);
        check("busy_level", 32'(o_level),    32'd1);
        check("busy_prio",  32'(o_cur_prio), 32'd1);
        check("busy_stall_off", 32'(o_stall), 32'd0);

        // Overflow at max nesting
        do_reset();
        do_irq(3'd1);
        do_irq(3'd2);
        do_irq(3'd3);
        sync();
        i_irq_prio  = 3'd7;
        i_irq_valid = 1'b1;
        @(negedge i_clk);
        check("ovf_flag", 32'(o_overflow), 32'd1);
        repeat (3) @(negedge i_clk);
        check("ovf_level_held", 32'(o_level), 32'd3);
        #1;
        i_irq_valid = 1'b0;
        repeat (3) @(negedge i_clk);
        check("ovf_sticky", 32'(o_overflow),  32'd1);
        check("ovf_level",  32'(o_level),     32'd3);
        check("ovf_prio",   32'(o_cur_prio),  32'd3);
        check("ovf_no_unf", 32'(o_underflow), 32'd0);

        // Simultaneous return and interrupt at level 1
        do_reset();
        do_irq(3'd3);
        sync();
        exp_q.push_back('{Command_pop,  1'b0, 1'b1, cyc + 2});
        exp_q.push_back('{Command_push, 1'b1, 1'b0, cyc + 5});
        i_irq_prio  = 3'd6;
        i_irq_valid = 1'b1;
        i_ret_valid = 1'b1;
        wait_ret_ready();
        @(negedge i_clk);
        check("sim_level0", 32'(o_level),    32'd0);
        check("sim_prio0",  32'(o_cur_prio), 32'd0);
        wait_irq_ready();
        @(negedge i_clk);
        check("sim_level1", 32'(o_level),    32'd1);
        check("sim_prio6",  32'(o_cur_prio), 32'd6);

        // Underflow: return at level 0
        do_reset();
        sync();
        exp_q.push_back('{Command_none, 1'b0, 1'b1, cyc + 1});
        i_ret_valid = 1'b1;
        wait_ret_ready();
        @(negedge i_clk);
        check("unf_flag",  32'(o_underflow), 32'd1);
        check("unf_level", 32'(o_level),     32'd0);
        repeat (3) @(negedge i_clk);
        check("unf_sticky", 32'(o_underflow), 32'd1);
        check("unf_no_ovf", 32'(o_overflow),  32'd0);

        repeat (4) @(negedge i_clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
